// File: rtl/axis2fifo_pcm_pack_pkg.sv
// Shared definitions for the PCM-to-FIFO packer.
// Lane order: lane 0 (bits [DATA_WIDTH-1:0]) carries the earliest sample of a
// word and is the first one the PWM player consumes.
package axis2fifo_pcm_pack_pkg;

    localparam int DEF_IN_WIDTH        = 16;
    localparam int DEF_DATA_WIDTH      = 8;
    localparam int DEF_FIFO_DATA_WIDTH = 32;

    // Offset-binary code for silence: 1 << (w-1)
    function automatic int unsigned midscale_of(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    // Width of a lane index for a word holding spw samples (at least 1 bit)
    function automatic int lane_width(input int spw);
        return (spw > 1) ? $clog2(spw) : 1;
    endfunction

endpackage

// File: rtl/axis2fifo_pcm_pack_pcm_to_offset.sv
// Combinational conversion of one signed PCM sample to unsigned offset-binary:
// round half-up at the truncation point, saturate at the positive rail, then
// keep the top DATA_WIDTH bits with the sign bit inverted.
module pcm_to_offset #(
    parameter int IN_WIDTH   = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic [IN_WIDTH-1:0]   x,
    output logic [DATA_WIDTH-1:0] y
);

    localparam logic [IN_WIDTH:0] ROUND = (IN_WIDTH+1)'(1) << (IN_WIDTH - DATA_WIDTH - 1);

    logic [IN_WIDTH:0]   r;
    logic                sat;
    logic [IN_WIDTH-1:0] rs;
    logic                unused_low;

    // Sign-extend, add half an output LSB; only a non-negative sum that spilled
    // into bit IN_WIDTH-1 can exceed the positive rail.
    always_comb begin
        r          = {x[IN_WIDTH-1], x} + ROUND;
        sat        = ~r[IN_WIDTH] & r[IN_WIDTH-1];
        rs         = sat ? {1'b0, {(IN_WIDTH-1){1'b1}}} : r[IN_WIDTH-1:0];
        y          = {~rs[IN_WIDTH-1], rs[IN_WIDTH-2 -: DATA_WIDTH-1]};
        unused_low = ^rs[IN_WIDTH-DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/axis2fifo_pcm_pack.sv
// AXI-Stream PCM sample packer feeding the playback FIFO write port.
// Samples are converted, packed lane 0 first into FIFO words, and a word is
// closed early (padded with midscale) when tlast arrives.
//
// Stream handshake: a sample transfers on a rising clk edge where
// s_axis_tvalid & s_axis_tready are both high; tready depends only on reset,
// the registered pending flag and fifo_full, never on tvalid.
module axis2fifo_pcm_pack
    import axis2fifo_pcm_pack_pkg::*;
#(
    parameter int IN_WIDTH        = DEF_IN_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int FIFO_DATA_WIDTH = DEF_FIFO_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IN_WIDTH-1:0]        s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_wr_data,
    output logic                       fifo_wr_en,
    input  logic                       fifo_full,
    output logic                       flush_pulse
);

    localparam int SPW    = FIFO_DATA_WIDTH / DATA_WIDTH;
    localparam int LANE_W = lane_width(SPW);
    localparam logic [DATA_WIDTH-1:0]      MIDSCALE = DATA_WIDTH'(midscale_of(DATA_WIDTH));
    localparam logic [FIFO_DATA_WIDTH-1:0] MID_WORD = {SPW{MIDSCALE}};
    localparam logic [LANE_W-1:0]          LAST_LANE = LANE_W'(SPW - 1);

    logic [LANE_W-1:0]          lane;
    logic [FIFO_DATA_WIDTH-1:0] pack_reg;
    logic [FIFO_DATA_WIDTH-1:0] out_reg;
    logic                       pending;
    logic                       out_flush;

    logic [DATA_WIDTH-1:0]      y;
    logic [FIFO_DATA_WIDTH-1:0] word_next;
    logic                       accept;
    logic                       complete;
    logic                       write;

    pcm_to_offset #(
        .IN_WIDTH  (IN_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_conv (
        .x(s_axis_tdata),
        .y(y)
    );

    // Handshake and write strobe; a stall only happens while a word waits on a full FIFO
    always_comb begin
        s_axis_tready = ~reset & ~(pending & fifo_full);
        accept        = s_axis_tvalid & s_axis_tready;
        complete      = accept & ((lane == LAST_LANE) | s_axis_tlast);
        write         = pending & ~fifo_full;
        fifo_wr_en    = write;
        fifo_wr_data  = out_reg;
        flush_pulse   = write & out_flush;
    end

    // Pack register with the incoming sample dropped into the current lane;
    // lanes above it still hold midscale from the last reload.
    always_comb begin
        word_next = pack_reg;
        for (int i = 0; i < SPW; i++) begin
            if (lane == LANE_W'(i)) begin
                word_next[i*DATA_WIDTH +: DATA_WIDTH] = y;
            end
        end
    end

    // Lane counter and pack register: advance per sample, reload on word completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane     <= '0;
            pack_reg <= MID_WORD;
        end else if (accept) begin
            if (complete) begin
                lane     <= '0;
                pack_reg <= MID_WORD;
            end else begin
                lane     <= lane + LANE_W'(1);
                pack_reg <= word_next;
            end
        end
    end

    // Output register and pending flag; a completion in a write cycle refills it at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg   <= '0;
            pending   <= 1'b0;
            out_flush <= 1'b0;
        end else if (complete) begin
            out_reg   <= word_next;
            pending   <= 1'b1;
            out_flush <= s_axis_tlast & (lane != LAST_LANE);
        end else if (write) begin
            pending   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis2fifo_pcm_pack.sv
// Bench for axis2fifo_pcm_pack: directed steps followed by a long randomized
// stream, all writes checked against a sample-level reference model.
module tb_axis2fifo_pcm_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] fifo_wr_data;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        flush_pulse;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] exp_q[$];
    logic        exp_flush_q[$];
    logic [31:0] part_m;
    int          lane_m;

    // fifo_full driving: 0 manual, 1 random, 2 held high for hold_cnt cycles
    int full_mode = 0;
    int hold_cnt  = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    axis2fifo_pcm_pack dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_full    (fifo_full),
        .flush_pulse  (flush_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference conversion in plain integer arithmetic
    function automatic logic [7:0] ref_conv(input logic [15:0] x);
        int v;
        v = int'($signed(x)) + 128;
        if (v > 32767) v = 32767;
        v = v >>> 8;
        return 8'(v + 128);
    endfunction

    task automatic model_reset();
        part_m = 32'h80808080;
        lane_m = 0;
    endtask

    task automatic model_accept(input logic [15:0] x, input logic last);
        part_m[lane_m*8 +: 8] = ref_conv(x);
        if (lane_m == 3 || last) begin
            exp_q.push_back(part_m);
            exp_flush_q.push_back(last && lane_m != 3);
            model_reset();
        end else begin
            lane_m++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        case (full_mode)
            1: fifo_full = ($urandom_range(0, 3) == 0);
            2: begin
                fifo_full = (hold_cnt > 0);
                if (hold_cnt > 0) hold_cnt--;
            end
            default: ;
        endcase
    endtask

    // Present one sample and return just after the edge that accepted it
    task automatic send(input logic [15:0] x, input logic last);
        int budget = 1000;
        tick();
        s_axis_tdata  = x;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        #1;
        while (!s_axis_tready && budget > 0) begin
            tick();
            #1;
            budget--;
        end
        if (!s_axis_tready) check("send_timeout", 32'(s_axis_tready), 32'd1);
        else model_accept(x, last);
        @(posedge clk);
    endtask

    task automatic idle_step();
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Scoreboard: every write must match the next expected word; a stalled word must hold
    always @(negedge clk) begin
        #2;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_data", fifo_wr_data, prev_data);
            if (fifo_wr_en) begin
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("wr_data", fifo_wr_data, exp_q.pop_front());
                    check("flush", 32'(flush_pulse), 32'(exp_flush_q.pop_front()));
                end
            end else begin
                check("flush_idle", 32'(flush_pulse), 32'd0);
            end
            prev_stall = ~s_axis_tready;
            prev_data  = fifo_wr_data;
        end
    end

    initial begin
        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        fifo_full     = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_wr_data", fifo_wr_data, 32'd0);
        check("rst_flush", 32'(flush_pulse), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("tready_after_rst", 32'(s_axis_tready), 32'd1);

        // full word, write one cycle after the 4th accept
        send(16'h0000, 1'b0);
        send(16'h7FFF, 1'b0);
        send(16'h8000, 1'b0);
        check("no_early_write", 32'(fifo_wr_en), 32'd0);
        send(16'h0080, 1'b0);
        idle_step();
        #1;
        check("t1_wr_en", 32'(fifo_wr_en), 32'd1);
        check("t1_data", fifo_wr_data, 32'h8100FF80);
        check("t1_flush", 32'(flush_pulse), 32'd0);
        idle_step();
        #1;
        check("t1_single_write", 32'(fifo_wr_en), 32'd0);

        // tlast after two samples pads with midscale
        send(16'h1000, 1'b0);
        send(16'hF000, 1'b1);
        idle_step();
        #1;
        check("t2_wr_en", 32'(fifo_wr_en), 32'd1);
        check("t2_data", fifo_wr_data, 32'h80807090);
        check("t2_flush", 32'(flush_pulse), 32'd1);
        idle_step();

        // FIFO full for 20 cycles under a continuous stream
        full_mode = 2;
        for (int i = 0; i < 40; i++) begin
            if (i == 6) hold_cnt = 20;
            send(16'($urandom), 1'b0);
        end
        full_mode = 0;
        fifo_full = 1'b0;
        idle_step();
        idle_step();

        // completion in the same cycle the previous word is finally written
        fifo_full = 1'b1;
        send(16'h0100, 1'b0);
        send(16'h0200, 1'b0);
        send(16'h0300, 1'b0);
        send(16'h0400, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle_step();
            #1;
            check("t4_stalled_wr_en", 32'(fifo_wr_en), 32'd0);
            check("t4_stalled_tready", 32'(s_axis_tready), 32'd0);
        end
        tick();
        fifo_full     = 1'b0;
        s_axis_tdata  = 16'hFE00;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        #1;
        check("t4_tready", 32'(s_axis_tready), 32'd1);
        check("t4_first_wr_en", 32'(fifo_wr_en), 32'd1);
        check("t4_first_data", fifo_wr_data, 32'h84838281);
        model_accept(16'hFE00, 1'b1);
        @(posedge clk);
        idle_step();
        #1;
        check("t4_second_wr_en", 32'(fifo_wr_en), 32'd1);
        check("t4_second_data", fifo_wr_data, 32'h8080807E);
        check("t4_second_flush", 32'(flush_pulse), 32'd1);
        idle_step();

        // reset in the middle of a word discards it
        send(16'h1234, 1'b0);
        send(16'h5678, 1'b0);
        tick();
        s_axis_tvalid = 1'b0;
        reset = 1'b1;
        #1;
        check("t5_rst_tready", 32'(s_axis_tready), 32'd0);
        check("t5_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        send(16'h007F, 1'b0);
        send(16'hFF80, 1'b0);
        send(16'h7F80, 1'b0);
        send(16'h8001, 1'b0);
        idle_step();
        #1;
        check("t5_wr_en", 32'(fifo_wr_en), 32'd1);
        check("t5_data", fifo_wr_data, 32'h00FF8080);
        idle_step();

        // randomized stream with random tvalid gaps, fifo_full and tlast
        full_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) idle_step();
            end
            send(16'($urandom), ($urandom_range(0, 7) == 0));
        end
        idle_step();
        full_mode = 0;
        fifo_full = 1'b0;

        // drain
        begin
            int budget = 200;
            while (exp_q.size() != 0 && budget > 0) begin
                idle_step();
                budget--;
            end
        end
        idle_step();
        idle_step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
